cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 4-bit clocked CLA.
- Operands are split into 4-bit CLA groups. Carry ripples group-to-group across register stages, so one operation is accepted per cycle.
- Valid/ready handshake on both sides, so it drops into datapath streams (ALU, accumulators) with backpressure.

---
 rtl/cla_pipe_adder.sv | 113 +++++++++++
 tb/tb_cla_pipe_adder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional `CLA_FLAGS_EN adds the registered ovf and zero result flags.
module cla_pipe_adder #(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             cin,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             cout
`ifdef CLA_FLAGS_EN
   ,
   output logic             ovf,
   output logic             zero
`endif
);

   localparam int GPS    = GROUPS_PER_STAGE;
   localparam int STAGES = WIDTH / (4 * GPS);

   // One 4-bit lookahead group, carries flattened; returns {carry_out, sum}.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic             vld_p [STAGES];
   logic [WIDTH-1:0] x_p   [STAGES];
   logic [WIDTH-1:0] ye_p  [STAGES];
   logic [WIDTH-1:0] s_p   [STAGES];
   logic             c_p   [STAGES];
   logic [WIDTH-1:0] s_nxt [STAGES];
   logic             c_nxt [STAGES];

   assign in_ready = !out_valid || out_ready;

   // Stage k adds its own groups; lower sum bits pass through, upper ones wait.
   always_comb begin
      logic cy;
      for (int k = 0; k < STAGES; k++) begin
         s_nxt[k] = s_p[k];
         cy       = c_p[k];
         for (int j = 0; j < GPS; j++) begin
            {cy, s_nxt[k][(k*GPS+j)*4 +: 4]} = cla4(x_p[k][(k*GPS+j)*4 +: 4],
                                                   ye_p[k][(k*GPS+j)*4 +: 4], cy);
         end
         c_nxt[k] = cy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_p[k] <= 1'b0;
            x_p[k]   <= '0;
            ye_p[k]  <= '0;
            s_p[k]   <= '0;
            c_p[k]   <= 1'b0;
         end
         out_valid <= 1'b0;
         r         <= '0;
         cout      <= 1'b0;
`ifdef CLA_FLAGS_EN
         ovf       <= 1'b0;
         zero      <= 1'b0;
`endif
      end else if (in_ready) begin
         // Input capture: the operand pair enters with its carry-in and an empty sum.
         vld_p[0] <= in_valid;
         x_p[0]   <= x;
         ye_p[0]  <= sub ? ~y : y;
         s_p[0]   <= '0;
         c_p[0]   <= cin;
         // Stage k-1 -> k: operands skew along, partial sum and group carry advance.
         for (int k = 1; k < STAGES; k++) begin
            vld_p[k] <= vld_p[k-1];
            x_p[k]   <= x_p[k-1];
            ye_p[k]  <= ye_p[k-1];
            s_p[k]   <= s_nxt[k-1];
            c_p[k]   <= c_nxt[k-1];
         end
         // Last stage -> output register.
         out_valid <= vld_p[STAGES-1];
         r         <= s_nxt[STAGES-1];
         cout      <= c_nxt[STAGES-1];
`ifdef CLA_FLAGS_EN
         ovf       <= (x_p[STAGES-1][WIDTH-1] == ye_p[STAGES-1][WIDTH-1])
                   && (s_nxt[STAGES-1][WIDTH-1] != x_p[STAGES-1][WIDTH-1]);
         zero      <= (s_nxt[STAGES-1] == '0);
`endif
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: a 16-bit/1-group instance and a 32-bit/2-group instance.
// Build with +define+CLA_FLAGS_EN to also check ovf and zero.
module tb_cla_pipe_adder;

   typedef struct {
      logic [31:0] r;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_cout;
   logic [15:0] a_x, a_y, a_r;
   logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready, b_cout;
   logic [31:0] b_x, b_y, b_r;
`ifdef CLA_FLAGS_EN
   logic        a_ovf, a_zero, b_ovf, b_zero;
`endif

   exp_t qa[$];
   exp_t qb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   chk_lat = 1'b0;
   int   ra_mode = 0;
   int   rb_mode = 0;

   cla_pipe_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .cin(a_cin), .sub(a_sub), .x(a_x), .y(a_y), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .r(a_r), .cout(a_cout)
`ifdef CLA_FLAGS_EN
      , .ovf(a_ovf), .zero(a_zero)
`endif
   );

   cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .cin(b_cin), .sub(b_sub), .x(b_x), .y(b_y), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .r(b_r), .cout(b_cout)
`ifdef CLA_FLAGS_EN
      , .ovf(b_ovf), .zero(b_zero)
`endif
   );

   function automatic void chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, got, exp);
      end
   endfunction

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic sb);
      exp_t   e;
      longint m, ye, t, sx, sy, s;
      m  = (longint'(1) << w) - 1;
      ye = sb ? (~longint'(y)) & m : longint'(y) & m;
      t  = longint'(x) + ye + longint'(ci);
      e.r    = 32'(t & m);
      e.cout = ((t >> w) & 1) != 0;
      sx = (((longint'(x) >> (w-1)) & 1) != 0) ? longint'(x) - (m + 1) : longint'(x);
      sy = (((ye >> (w-1)) & 1) != 0) ? ye - (m + 1) : ye;
      s  = sx + sy + longint'(ci);
      e.ovf  = (s > (m >> 1)) || (s < -((m >> 1) + 1));
      e.zero = (e.r == 0);
      e.acc  = 0;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      a_out_ready = (ra_mode == 1) ? 1'($urandom_range(0, 1)) : (ra_mode == 0);
      b_out_ready = (rb_mode == 1) ? 1'($urandom_range(0, 1)) : (rb_mode == 0);
   end

   // Monitor A: compares each transferred result and checks stall stability.
   logic        a_pv = 1'b0;
   logic [15:0] a_pr;
   logic        a_pc;
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n) begin
         chk("a_in_ready", a_in_ready, !a_out_valid || a_out_ready);
         if (a_pv) begin
            chk("a_hold_valid", a_out_valid, 1);
            chk("a_hold_r", a_r, a_pr);
            chk("a_hold_cout", a_cout, a_pc);
         end
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL a_extra: got r=%0h expected no result", a_r);
            end else begin
               e = qa.pop_front();
               chk("a_r", a_r, e.r);
               chk("a_cout", a_cout, e.cout);
`ifdef CLA_FLAGS_EN
               chk("a_ovf", a_ovf, e.ovf);
               chk("a_zero", a_zero, e.zero);
`endif
               if (chk_lat) chk("a_latency", cyc - e.acc, 4);
            end
         end
         a_pv = a_out_valid && !a_out_ready;
         a_pr = a_r;
         a_pc = a_cout;
      end else a_pv = 1'b0;
   end

   // Monitor B: same for the 32-bit instance.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rst_n) begin
         chk("b_in_ready", b_in_ready, !b_out_valid || b_out_ready);
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_extra: got r=%0h expected no result", b_r);
            end else begin
               e = qb.pop_front();
               chk("b_r", b_r, e.r);
               chk("b_cout", b_cout, e.cout);
`ifdef CLA_FLAGS_EN
               chk("b_ovf", b_ovf, e.ovf);
               chk("b_zero", b_zero, e.zero);
`endif
               if (chk_lat) chk("b_latency", cyc - e.acc, 4);
            end
         end
      end
   end

   task automatic send_a(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
      bit   acc;
      exp_t e;
      do begin
         @(negedge clk);
         a_in_valid = 1'b1; a_x = x; a_y = y; a_cin = ci; a_sub = sb;
         #1 acc = a_in_ready;
         @(posedge clk);
      end while (!acc);
      #1 a_in_valid = 1'b0;
      e = model(16, 32'(x), 32'(y), ci, sb);
      e.acc = cyc;
      qa.push_back(e);
   endtask

   task automatic send_b(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
      bit   acc;
      exp_t e;
      do begin
         @(negedge clk);
         b_in_valid = 1'b1; b_x = x; b_y = y; b_cin = ci; b_sub = sb;
         #1 acc = b_in_ready;
         @(posedge clk);
      end while (!acc);
      #1 b_in_valid = 1'b0;
      e = model(32, x, y, ci, sb);
      e.acc = cyc;
      qb.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("drain_pending", 64'(qa.size() + qb.size()), 0);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      rst_n = 1'b0;
      a_in_valid = 0; a_cin = 0; a_sub = 0; a_x = 0; a_y = 0;
      b_in_valid = 0; b_cin = 0; b_sub = 0; b_x = 0; b_y = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_a_valid", a_out_valid, 0);
      chk("rst_a_r", a_r, 0);
      chk("rst_a_cout", a_cout, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_b_r", b_r, 0);
`ifdef CLA_FLAGS_EN
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_a_zero", a_zero, 0);
`endif
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("rel_a_in_ready", a_in_ready, 1);
      chk("rel_b_in_ready", b_in_ready, 1);

      // Pass-through, signed-overflow sums and subtraction with exact latency.
      chk_lat = 1'b1;
      for (int i = 0; i < 15; i++) send_a(16'(i), 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) send_a(16'h8000 + 16'(i), 16'h8000 + 16'(i), 1'b1, 1'b0);
      send_a(16'h1234, 16'h1234, 1'b1, 1'b1);
      send_a(16'h0001, 16'h0002, 1'b1, 1'b1);
      send_a(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      drain();
      chk_lat = 1'b0;

      // Backpressure: 10 beats with a 5-cycle consumer stall mid-stream.
      fork
         begin
            for (int i = 0; i < 10; i++) send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (6) @(negedge clk);
            ra_mode = 2;
            repeat (5) @(negedge clk);
            ra_mode = 0;
         end
      join
      drain();

      // Reset with three beats in flight: they must never emerge.
      for (int i = 0; i < 3; i++) send_a(16'(100 + i), 16'h0011, 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst_a_valid", a_out_valid, 0);
      chk("midrst_a_r", a_r, 0);
      qa.delete();
      @(negedge clk) rst_n = 1'b1;
      #1;
      chk("midrst_in_ready", a_in_ready, 1);
      chk_lat = 1'b1;
      send_a(16'h4321, 16'h1111, 1'b0, 1'b1);
      drain();
      chk_lat = 1'b0;

      // Random 16-bit stream with random consumer readiness and input gaps.
      ra_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send_a(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      ra_mode = 0;
      drain();

      // 32-bit, two groups per stage: full carry ripple, then random stream.
      chk_lat = 1'b1;
      send_b(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      send_b(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      drain();
      chk_lat = 1'b0;
      rb_mode = 1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 7) == 0) @(negedge clk);
         send_b($urandom, $urandom, 1'($urandom), 1'($urandom));
      end
      rb_mode = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
